// File: rtl/zone_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : zone_event_logger
// Brief    : Timestamps every zone-code change and queues {ts, old, new, price}
//            records in a FIFO drained over valid/ready; drops are counted.
// Revision : 1.0  initial release
// ============================================================================
module zone_event_logger #(
  parameter int TS_WIDTH = 16,
  parameter int DEPTH    = 8,
  parameter int DROP_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 zone,
  input  logic [7:0]                 price,
  input  logic                       evt_ready,
  input  logic                       clr_overflow,
  output logic                       evt_valid,
  output logic [TS_WIDTH+11:0]       evt_data,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_FW = $clog2(DEPTH + 1);
  localparam int c_RW = TS_WIDTH + 12;
  localparam logic [c_FW-1:0] c_FULL = c_FW'(DEPTH);

  logic [TS_WIDTH-1:0] r_ts;
  logic [1:0]          r_prev_zone;
  logic [c_RW-1:0]     r_mem [DEPTH];
  logic [c_AW-1:0]     r_wr_ptr;
  logic [c_AW-1:0]     r_rd_ptr;
  logic [c_FW-1:0]     r_fill;
  logic                r_overflow;
  logic [DROP_W-1:0]   r_drop_count;

  logic                w_event;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [c_RW-1:0]     w_record;

  assign w_event  = (zone != r_prev_zone);
  assign w_pop    = (r_fill != '0) && evt_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push   = w_event && ((r_fill < c_FULL) || w_pop);
  assign w_drop   = w_event && !w_push;
  assign w_record = {r_ts, r_prev_zone, zone, price};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts        <= '0;
      r_prev_zone <= 2'b00;
    end else begin
      r_ts        <= r_ts + TS_WIDTH'(1);
      r_prev_zone <= zone;
    end
  end

  // Storage carries no reset; emptiness is defined by the pointers and fill.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= w_record;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      if (w_push && !w_pop) begin
        r_fill <= r_fill + c_FW'(1);
      end else if (!w_push && w_pop) begin
        r_fill <= r_fill - c_FW'(1);
      end
    end
  end

  // A drop on the clearing edge wins, restarting the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_overflow) begin
        r_drop_count <= DROP_W'(1);
      end else if (r_drop_count != '1) begin
        r_drop_count <= r_drop_count + DROP_W'(1);
      end
    end else if (clr_overflow) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign evt_valid  = (r_fill != '0);
  assign evt_data   = r_mem[r_rd_ptr];
  assign fill       = r_fill;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_zone_event_logger.sv
`default_nettype none
// Testbench for zone_event_logger: randomized and directed stimulus against a
// queue-based reference model, with a negedge monitor acting as scoreboard.
module tb_zone_event_logger;

  localparam int TS_WIDTH = 16;
  localparam int DEPTH    = 8;
  localparam int DROP_W   = 8;
  localparam int RW       = TS_WIDTH + 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    zone = 2'b00;
  logic [7:0]    price = 8'd0;
  logic          evt_ready = 1'b0;
  logic          clr_overflow = 1'b0;
  logic          evt_valid;
  logic [RW-1:0] evt_data;
  logic [3:0]    fill;
  logic          overflow;
  logic [7:0]    drop_count;

  zone_event_logger #(
    .TS_WIDTH(TS_WIDTH),
    .DEPTH   (DEPTH),
    .DROP_W  (DROP_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .zone        (zone),
    .price       (price),
    .evt_ready   (evt_ready),
    .clr_overflow(clr_overflow),
    .evt_valid   (evt_valid),
    .evt_data    (evt_data),
    .fill        (fill),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a record queue bounded at DEPTH, evaluated at each edge.
  logic [RW-1:0] m_q[$];
  logic [15:0]   m_ts = 16'd0;
  logic [1:0]    m_prev = 2'b00;
  bit            m_ovf = 1'b0;
  int            m_drops = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_ts    = 16'd0;
      m_prev  = 2'b00;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      if (evt_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (clr_overflow) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end
      if (zone != m_prev) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back({m_ts, m_prev, zone, price});
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
      m_prev = zone;
      m_ts   = m_ts + 16'd1;
    end
  end

  // Monitor: compares DUT outputs with the model head every cycle.
  always @(negedge clk) begin
    if (armed) begin
      check("valid", {63'd0, evt_valid}, {63'd0, m_q.size() != 0});
      check("fill", {60'd0, fill}, 64'(m_q.size()));
      check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
      check("drop_count", {56'd0, drop_count}, 64'(m_drops));
      if (evt_valid && m_q.size() != 0)
        check("evt_data", {36'd0, evt_data}, {36'd0, m_q[0]});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic toggle(input int n);
    for (int i = 0; i < n; i++) begin
      zone  = (zone == 2'b01) ? 2'b11 : 2'b01;
      price = 8'($urandom_range(0, 255));
      step(1);
    end
  endtask

  initial begin
    step(1);
    armed = 1'b1;
    do_reset();

    // Idle: zone held at 00 produces nothing.
    evt_ready = 1'b1;
    step(10);
    check("idle_valid", {63'd0, evt_valid}, 64'd0);
    check("idle_fill", {60'd0, fill}, 64'd0);
    check("idle_ovf", {63'd0, overflow}, 64'd0);

    // First event at ts = 5.
    do_reset();
    step(5);
    zone = 2'b01; price = 8'd100; evt_ready = 1'b0;
    step(1);
    check("first_valid", {63'd0, evt_valid}, 64'd1);
    check("first_data", {36'd0, evt_data}, {36'd0, 16'd5, 2'b00, 2'b01, 8'd100});
    evt_ready = 1'b1;
    step(1);
    check("first_pop_fill", {60'd0, fill}, 64'd0);

    // Fill to DEPTH, then one more change is dropped.
    evt_ready = 1'b0;
    toggle(8);
    check("full_fill", {60'd0, fill}, 64'd8);
    toggle(1);
    check("drop_fill", {60'd0, fill}, 64'd8);
    check("drop_ovf", {63'd0, overflow}, 64'd1);
    check("drop_cnt", {56'd0, drop_count}, 64'd1);

    // Full with simultaneous pop accepts the push.
    evt_ready = 1'b1;
    toggle(1);
    check("pp_fill", {60'd0, fill}, 64'd8);
    check("pp_cnt", {56'd0, drop_count}, 64'd1);
    step(10);
    check("drained", {60'd0, fill}, 64'd0);

    // Saturating drop counter and clear behaviour.
    evt_ready = 1'b0;
    toggle(8 + 300);
    check("sat_cnt", {56'd0, drop_count}, 64'd255);
    clr_overflow = 1'b1;
    step(1);
    check("clr_ovf", {63'd0, overflow}, 64'd0);
    check("clr_cnt", {56'd0, drop_count}, 64'd0);
    toggle(1);
    clr_overflow = 1'b0;
    check("clr_drop_ovf", {63'd0, overflow}, 64'd1);
    check("clr_drop_cnt", {56'd0, drop_count}, 64'd1);
    evt_ready = 1'b1;
    step(10);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) zone = 2'($urandom_range(0, 3));
      price        = 8'($urandom_range(0, 255));
      evt_ready    = ($urandom_range(0, 99) < 40);
      clr_overflow = ($urandom_range(0, 19) == 0);
      step(1);
    end
    clr_overflow = 1'b0;
    evt_ready    = 1'b1;
    step(10);

    // Timestamp wrap: events at ts = FFFF and ts = 0000.
    zone = 2'b00;
    do_reset();
    evt_ready = 1'b0;
    step(65535);
    zone = 2'b01; price = 8'd7;
    step(1);
    check("wrap_hi", {36'd0, evt_data}, {36'd0, 16'hFFFF, 2'b00, 2'b01, 8'd7});
    zone = 2'b10; price = 8'd9; evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("wrap_lo", {36'd0, evt_data}, {36'd0, 16'h0000, 2'b01, 2'b10, 8'd9});

    // Reset mid-stream discards buffered records.
    toggle(4);
    check("pre_rst_fill", {60'd0, fill}, 64'd5);
    reset = 1'b1;
    step(1);
    check("rst_valid", {63'd0, evt_valid}, 64'd0);
    check("rst_fill", {60'd0, fill}, 64'd0);
    reset = 1'b0;
    zone = 2'b10; price = 8'd42;
    step(1);
    check("post_rst_data", {36'd0, evt_data}, {36'd0, 16'd0, 2'b00, 2'b10, 8'd42});
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
